// File: rtl/plic_pkg.sv
// plic_pkg: shared constants, gateway state type and a byte-merge helper
// for the PLIC core and its per-source gateways.
package plic_pkg;

   localparam int ADDR_W = 26;

   localparam logic [ADDR_W-1:0] PRIO_BASE  = 26'h000000;
   localparam logic [ADDR_W-1:0] PEND_BASE  = 26'h001000;
   localparam logic [ADDR_W-1:0] EN_BASE    = 26'h002000;
   localparam logic [ADDR_W-1:0] EN_STRIDE  = 26'h000080;
   localparam logic [ADDR_W-1:0] CTX_BASE   = 26'h200000;
   localparam logic [ADDR_W-1:0] CTX_STRIDE = 26'h001000;
   localparam logic [ADDR_W-1:0] CLAIM_OFF  = 26'h000004;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PEND     = 2'd1,
      INFLIGHT = 2'd2
   } gw_state_e;

   function automatic logic [31:0] merge_bytes(
      input logic [31:0] old,
      input logic [31:0] wdata,
      input logic [3:0]  wstrb
   );
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/plic_gateway.sv
// plic_gateway: level-source synchroniser plus IDLE/PEND/INFLIGHT gateway.
// Ports: clk, rst_n, src (raw level), claim/complete pulses, pending/inflight.
module plic_gateway
   import plic_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic src,
   input  logic claim,
   input  logic complete,
   output logic pending,
   output logic inflight
);

   logic      src_s;
   gw_state_e state_q;
   gw_state_e state_d;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign src_s = src;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= '0;
         end else begin
            sync_q[0] <= src;
            for (int k = 1; k < SYNC_STAGES; k++)
               sync_q[k] <= sync_q[k-1];
         end
      end
      assign src_s = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // A completed source drops to IDLE first; a still-high level
   // re-pends on the following cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (src_s)    state_d = PEND;
         PEND:     if (claim)    state_d = INFLIGHT;
         INFLIGHT: if (complete) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   assign pending  = (state_q == PEND);
   assign inflight = (state_q == INFLIGHT);

endmodule

// File: rtl/plic_core.sv
// plic_core: PLIC register file, per-target arbiter and claim/complete.
// Ports: PCLK/PRESETn, src levels, reg_* single-word access port, irq.
module plic_core
   import plic_pkg::*;
#(
   parameter int NSRC        = 31,
   parameter int NTGT        = 2,
   parameter int PRIO_W      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic [NSRC-1:0]   src,
   input  logic              reg_req,
   input  logic              reg_we,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [31:0]       reg_wdata,
   input  logic [3:0]        reg_wstrb,
   output logic              reg_ack,
   output logic [31:0]       reg_rdata,
   output logic              reg_err,
   output logic [NTGT-1:0]   irq
);

   localparam int TW = (NTGT > 1) ? $clog2(NTGT) : 1;
   localparam logic [4:0] NSRC5 = 5'(NSRC);
   localparam logic [63:0] SRC_M64 = (64'd1 << (NSRC + 1)) - 64'd2;
   localparam logic [31:0] SRC_MASK = SRC_M64[31:0];
   localparam logic [ADDR_W-1:0] EN_SPAN =
      EN_STRIDE * ADDR_W'(NTGT);
   localparam logic [ADDR_W-1:0] CTX_SPAN =
      CTX_STRIDE * ADDR_W'(NTGT);

   logic [PRIO_W-1:0] prio_q [32];
   logic [31:0]       en_q   [NTGT];
   logic [PRIO_W-1:0] thr_q  [NTGT];
   logic [4:0]        best_q [NTGT];
   logic [4:0]        best_d [NTGT];
   logic [PRIO_W-1:0] best_p [NTGT];

   logic [31:0] pend_v;
   logic [31:0] infl_v;
   logic [31:0] claim_v;
   logic [31:0] cmpl_v;

   assign pend_v[0] = 1'b0;
   assign infl_v[0] = 1'b0;

   for (genvar i = 1; i < 32; i++) begin : g_gw
      if (i <= NSRC) begin : g_src
         plic_gateway #(
            .SYNC_STAGES(SYNC_STAGES)
         ) u_gw (
            .clk     (PCLK),
            .rst_n   (PRESETn),
            .src     (src[i-1]),
            .claim   (claim_v[i]),
            .complete(cmpl_v[i]),
            .pending (pend_v[i]),
            .inflight(infl_v[i])
         );
      end else begin : g_tie
         assign pend_v[i] = 1'b0;
         assign infl_v[i] = 1'b0;
      end
   end

   // Address decode
   logic [ADDR_W-1:0] a;
   logic [ADDR_W-1:0] en_off;
   logic [ADDR_W-1:0] ctx_off;
   logic [4:0]        pidx;
   logic [1:0]        en_t2;
   logic [1:0]        ctx_t2;
   logic [TW-1:0]     en_t;
   logic [TW-1:0]     ctx_t;
   logic prio_hit, pend_hit, en_hit, thr_hit, clm_hit;

   always_comb begin
      a        = {reg_addr[ADDR_W-1:2], 2'b00};
      en_off   = a - EN_BASE;
      ctx_off  = a - CTX_BASE;
      pidx     = a[6:2];
      en_t2    = en_off[8:7];
      ctx_t2   = ctx_off[13:12];
      en_t     = en_t2[TW-1:0];
      ctx_t    = ctx_t2[TW-1:0];
      prio_hit = (a[ADDR_W-1:7] == '0) && (pidx <= NSRC5);
      pend_hit = (a == PEND_BASE);
      en_hit   = (a >= EN_BASE) && (en_off < EN_SPAN) &&
                 (en_off[6:0] == '0);
      thr_hit  = (a >= CTX_BASE) && (ctx_off < CTX_SPAN) &&
                 (ctx_off[11:0] == '0);
      clm_hit  = (a >= CTX_BASE) && (ctx_off < CTX_SPAN) &&
                 (ctx_off[11:0] == CLAIM_OFF[11:0]);
   end

   // Arbiter: strict > keeps the lowest ID on a priority tie
   always_comb begin
      for (int t = 0; t < NTGT; t++) begin
         best_d[t] = '0;
         best_p[t] = '0;
         for (int i = 1; i <= NSRC; i++) begin
            if (pend_v[i] && en_q[t][i] &&
                prio_q[i] > thr_q[t] &&
                prio_q[i] > best_p[t]) begin
               best_d[t] = 5'(i);
               best_p[t] = prio_q[i];
            end
         end
      end
   end

   // Access side effects and read mux
   logic [31:0] rd;
   logic        err;
   logic [4:0]  cid;
   logic [4:0]  claim_id;
   logic        claim_ok;
   logic [31:0] wm_prio;
   logic [31:0] wm_en;
   logic [31:0] wm_thr;

   always_comb begin
      rd       = '0;
      err      = 1'b0;
      claim_v  = '0;
      cmpl_v   = '0;
      cid      = reg_wdata[4:0];
      claim_id = best_q[ctx_t];
      // best_q lags a claim by a cycle; only a still-pending ID counts
      claim_ok = (claim_id != '0) && pend_v[claim_id];
      wm_prio  = merge_bytes(32'(prio_q[pidx]), reg_wdata, reg_wstrb);
      wm_en    = merge_bytes(en_q[en_t], reg_wdata, reg_wstrb);
      wm_thr   = merge_bytes(32'(thr_q[ctx_t]), reg_wdata, reg_wstrb);
      unique case (1'b1)
         prio_hit: rd = 32'(prio_q[pidx]);
         pend_hit: rd = pend_v;
         en_hit:   rd = en_q[en_t];
         thr_hit:  rd = 32'(thr_q[ctx_t]);
         clm_hit: begin
            rd = claim_ok ? 32'(claim_id) : '0;
            if (reg_req && !reg_we && claim_ok)
               claim_v = 32'h1 << claim_id;
            if (reg_req && reg_we && reg_wstrb[0] &&
                cid != '0 && cid <= NSRC5 &&
                en_q[ctx_t][cid] && infl_v[cid])
               cmpl_v = 32'h1 << cid;
         end
         default:  err = 1'b1;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         reg_ack   <= 1'b0;
         reg_err   <= 1'b0;
         reg_rdata <= '0;
         irq       <= '0;
         for (int i = 0; i < 32; i++) prio_q[i] <= '0;
         for (int t = 0; t < NTGT; t++) begin
            en_q[t]   <= '0;
            thr_q[t]  <= '0;
            best_q[t] <= '0;
         end
      end else begin
         reg_ack   <= reg_req;
         reg_err   <= reg_req && err;
         reg_rdata <= (reg_req && !reg_we) ? rd : '0;
         for (int t = 0; t < NTGT; t++) begin
            best_q[t] <= best_d[t];
            irq[t]    <= (best_q[t] != '0);
         end
         if (reg_req && reg_we) begin
            if (prio_hit && pidx != '0)
               prio_q[pidx] <= wm_prio[PRIO_W-1:0];
            if (en_hit)
               en_q[en_t] <= wm_en & SRC_MASK;
            if (thr_hit)
               thr_q[ctx_t] <= wm_thr[PRIO_W-1:0];
         end
      end
   end

   wire unused_ok = ^{reg_addr[1:0], en_t2, ctx_t2, wm_prio,
                      wm_thr, claim_v, cmpl_v, infl_v};

endmodule

// File: tb/tb_plic_core.sv
// tb_plic_core: directed self-checking bench for plic_core.
// Drives reg_* on negedges, samples one negedge later.
module tb_plic_core;

   localparam int NSRC = 31;
   localparam int NTGT = 2;

   logic              PCLK = 1'b0;
   logic              PRESETn = 1'b0;
   logic [NSRC-1:0]   src = '0;
   logic              reg_req = 1'b0;
   logic              reg_we = 1'b0;
   logic [25:0]       reg_addr = '0;
   logic [31:0]       reg_wdata = '0;
   logic [3:0]        reg_wstrb = '0;
   logic              reg_ack;
   logic [31:0]       reg_rdata;
   logic              reg_err;
   logic [NTGT-1:0]   irq;

   int n_cmp = 0;
   int n_bad = 0;

   logic        got_ack;
   logic        got_err;
   logic [31:0] got_rd;

   always #5 PCLK = ~PCLK;

   plic_core #(
      .NSRC(NSRC), .NTGT(NTGT), .PRIO_W(3), .SYNC_STAGES(2)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .src(src),
      .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
      .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err),
      .irq(irq)
   );

   function automatic logic [25:0] prio_a(input int i);
      return 26'(4 * i);
   endfunction
   function automatic logic [25:0] en_a(input int t);
      return 26'h2000 + 26'(t * 'h80);
   endfunction
   function automatic logic [25:0] thr_a(input int t);
      return 26'h200000 + 26'(t * 'h1000);
   endfunction
   function automatic logic [25:0] clm_a(input int t);
      return 26'h200004 + 26'(t * 'h1000);
   endfunction

   task automatic access(input logic we, input logic [25:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws);
      @(negedge PCLK);
      reg_req = 1'b1; reg_we = we; reg_addr = addr;
      reg_wdata = wd; reg_wstrb = ws;
      @(negedge PCLK);
      reg_req = 1'b0; reg_we = 1'b0;
      got_ack = reg_ack; got_rd = reg_rdata; got_err = reg_err;
   endtask

   task automatic rd(input logic [25:0] addr);
      access(1'b0, addr, 32'h0, 4'h0);
   endtask

   task automatic wr(input logic [25:0] addr, input logic [31:0] d);
      access(1'b1, addr, d, 4'hF);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic test_reset;
      logic [25:0] addrs [6];
      addrs[0] = prio_a(3); addrs[1] = 26'h1000;
      addrs[2] = en_a(0);   addrs[3] = en_a(1);
      addrs[4] = thr_a(0);  addrs[5] = thr_a(1);
      PRESETn = 1'b0;
      idle(3);
      n_cmp++;
      if (irq !== 2'b00 || reg_ack !== 1'b0 || reg_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_outs irq=%b ack=%b rd=%h exp 0",
                  irq, reg_ack, reg_rdata);
      end
      PRESETn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         rd(addrs[k]);
         n_cmp++;
         if (got_rd !== 32'h0 || got_ack !== 1'b1 || got_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_read[%0d] rd=%h ack=%b err=%b exp 0/1/0",
                     k, got_rd, got_ack, got_err);
         end
      end
      wr(prio_a(3), 32'h5);
      rd(prio_a(3));
      n_cmp++;
      if (got_rd !== 32'h5 || got_ack !== 1'b1) begin
         n_bad++;
         $display("FAIL prio3_readback rd=%h ack=%b exp 5/1",
                  got_rd, got_ack);
      end
      idle(1);
      n_cmp++;
      if (reg_ack !== 1'b0) begin
         n_bad++;
         $display("FAIL ack_pulse ack=%b exp 0", reg_ack);
      end
      access(1'b1, prio_a(3), 32'h0000_0007, 4'b0010);
      rd(prio_a(3));
      n_cmp++;
      if (got_rd !== 32'h5) begin
         n_bad++;
         $display("FAIL wstrb_mask rd=%h exp 5", got_rd);
      end
      wr(prio_a(0), 32'h7);
      rd(prio_a(0));
      n_cmp++;
      if (got_rd !== 32'h0 || got_err !== 1'b0) begin
         n_bad++;
         $display("FAIL prio0 rd=%h err=%b exp 0/0", got_rd, got_err);
      end
      wr(en_a(0), 32'hFFFF_FFFF);
      rd(en_a(0));
      n_cmp++;
      if (got_rd !== 32'hFFFF_FFFE) begin
         n_bad++;
         $display("FAIL en_bit0 rd=%h exp fffffffe", got_rd);
      end
      wr(en_a(0), 32'h0);
   endtask

   task automatic test_basic;
      wr(en_a(0), 32'h8);
      wr(thr_a(0), 32'h0);
      src[2] = 1'b1;
      idle(8);
      rd(26'h1000);
      n_cmp++;
      if (got_rd !== 32'h8 || irq !== 2'b01) begin
         n_bad++;
         $display("FAIL basic_pend rd=%h irq=%b exp 8/01", got_rd, irq);
      end
      rd(clm_a(0));
      n_cmp++;
      if (got_rd !== 32'd3) begin
         n_bad++;
         $display("FAIL basic_claim rd=%0d exp 3", got_rd);
      end
      idle(3);
      rd(26'h1000);
      n_cmp++;
      if (got_rd !== 32'h0 || irq !== 2'b00) begin
         n_bad++;
         $display("FAIL basic_inflight rd=%h irq=%b exp 0/00", got_rd, irq);
      end
      wr(clm_a(0), 32'd3);
      idle(8);
      rd(26'h1000);
      n_cmp++;
      if (got_rd !== 32'h8 || irq !== 2'b01) begin
         n_bad++;
         $display("FAIL basic_repend rd=%h irq=%b exp 8/01", got_rd, irq);
      end
      rd(clm_a(0));
      n_cmp++;
      if (got_rd !== 32'd3) begin
         n_bad++;
         $display("FAIL basic_claim2 rd=%0d exp 3", got_rd);
      end
      src[2] = 1'b0;
      idle(4);
      wr(clm_a(0), 32'd3);
      idle(6);
      rd(26'h1000);
      n_cmp++;
      if (got_rd !== 32'h0 || irq !== 2'b00) begin
         n_bad++;
         $display("FAIL basic_idle rd=%h irq=%b exp 0/00", got_rd, irq);
      end
   endtask

   task automatic test_arbitration;
      logic [31:0] exp_id [4];
      logic [31:0] first;
      logic [31:0] second;
      logic        ack2;
      exp_id[0] = 7; exp_id[1] = 9; exp_id[2] = 4; exp_id[3] = 0;
      wr(prio_a(4), 32'd2);
      wr(prio_a(7), 32'd6);
      wr(prio_a(9), 32'd6);
      wr(en_a(0), 32'h290);
      src[3] = 1'b1; src[6] = 1'b1; src[8] = 1'b1;
      idle(8);
      for (int k = 0; k < 4; k++) begin
         rd(clm_a(0));
         n_cmp++;
         if (got_rd !== exp_id[k]) begin
            n_bad++;
            $display("FAIL arb_claim[%0d] rd=%0d exp %0d",
                     k, got_rd, exp_id[k]);
         end
         idle(3);
      end
      wr(clm_a(0), 32'd7);
      wr(clm_a(0), 32'd9);
      wr(clm_a(0), 32'd4);
      idle(8);
      @(negedge PCLK);
      reg_req = 1'b1; reg_we = 1'b0; reg_addr = clm_a(0);
      @(negedge PCLK);
      first = reg_rdata;
      @(negedge PCLK);
      reg_req = 1'b0;
      second = reg_rdata;
      ack2 = reg_ack;
      n_cmp++;
      if (first !== 32'd7 || second !== 32'd0 || ack2 !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_claim got %0d,%0d ack=%b exp 7,0 ack=1",
                  first, second, ack2);
      end
      src[3] = 1'b0; src[6] = 1'b0; src[8] = 1'b0;
      idle(4);
      wr(clm_a(0), 32'd7);
      idle(3);
      rd(clm_a(0));
      n_cmp++;
      if (got_rd !== 32'd9) begin
         n_bad++;
         $display("FAIL latched_9 rd=%0d exp 9", got_rd);
      end
      idle(3);
      wr(clm_a(0), 32'd9);
      idle(3);
      rd(clm_a(0));
      n_cmp++;
      if (got_rd !== 32'd4) begin
         n_bad++;
         $display("FAIL latched_4 rd=%0d exp 4", got_rd);
      end
      idle(3);
      wr(clm_a(0), 32'd4);
      idle(3);
      rd(26'h1000);
      n_cmp++;
      if (got_rd !== 32'h0) begin
         n_bad++;
         $display("FAIL arb_drain pend=%h exp 0", got_rd);
      end
   endtask

   task automatic test_threshold;
      wr(en_a(0), 32'h20);
      wr(prio_a(5), 32'd3);
      wr(thr_a(0), 32'd3);
      src[4] = 1'b1;
      idle(8);
      n_cmp++;
      if (irq[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL thr_equal irq0=%b exp 0", irq[0]);
      end
      rd(26'h1000);
      n_cmp++;
      if (got_rd !== 32'h20) begin
         n_bad++;
         $display("FAIL thr_pend rd=%h exp 20", got_rd);
      end
      wr(thr_a(0), 32'd2);
      idle(1);
      n_cmp++;
      if (irq[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL thr_lat1 irq0=%b exp 0", irq[0]);
      end
      idle(1);
      n_cmp++;
      if (irq[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL thr_lat2 irq0=%b exp 1", irq[0]);
      end
      wr(thr_a(0), 32'd0);
      wr(prio_a(5), 32'd0);
      idle(3);
      n_cmp++;
      if (irq[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL prio0_noirq irq0=%b exp 0", irq[0]);
      end
      wr(prio_a(5), 32'd3);
      idle(3);
      rd(clm_a(0));
      n_cmp++;
      if (got_rd !== 32'd5 || irq[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL thr_claim rd=%0d irq0=%b exp 5/1", got_rd, irq[0]);
      end
      src[4] = 1'b0;
      idle(4);
      wr(clm_a(0), 32'd5);
      idle(4);
   endtask

   task automatic test_illegal;
      logic [25:0] bad [5];
      bad[0] = 26'h3FFFFC; bad[1] = prio_a(32);
      bad[2] = en_a(2);    bad[3] = thr_a(2);
      bad[4] = 26'h200008;
      for (int k = 0; k < 5; k++) begin
         rd(bad[k]);
         n_cmp++;
         if (got_err !== 1'b1 || got_rd !== 32'h0 || got_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_addr[%0d] err=%b rd=%h ack=%b exp 1/0/1",
                     k, got_err, got_rd, got_ack);
         end
      end
      wr(26'h1000, 32'hFFFF_FFFF);
      n_cmp++;
      if (got_err !== 1'b0) begin
         n_bad++;
         $display("FAIL pend_write err=%b exp 0", got_err);
      end
      wr(prio_a(12), 32'd1);
      wr(en_a(0), 32'h1000);
      src[11] = 1'b1;
      idle(8);
      wr(clm_a(0), 32'd12);
      idle(3);
      rd(26'h1000);
      n_cmp++;
      if (got_rd !== 32'h1000 || irq[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL cmpl_not_inflight pend=%h irq0=%b exp 1000/1",
                  got_rd, irq[0]);
      end
      rd(clm_a(0));
      n_cmp++;
      if (got_rd !== 32'd12) begin
         n_bad++;
         $display("FAIL claim12 rd=%0d exp 12", got_rd);
      end
      src[11] = 1'b0;
      idle(4);
      wr(clm_a(0), 32'd12);
      idle(4);
      rd(clm_a(0));
      n_cmp++;
      if (got_rd !== 32'd0 || got_err !== 1'b0) begin
         n_bad++;
         $display("FAIL claim_empty rd=%0d err=%b exp 0/0", got_rd, got_err);
      end
   endtask

   task automatic test_two_targets;
      wr(prio_a(6), 32'd4);
      wr(en_a(0), 32'h40);
      wr(en_a(1), 32'h40);
      wr(thr_a(1), 32'd0);
      src[5] = 1'b1;
      idle(8);
      n_cmp++;
      if (irq !== 2'b11) begin
         n_bad++;
         $display("FAIL two_irq irq=%b exp 11", irq);
      end
      rd(clm_a(0));
      n_cmp++;
      if (got_rd !== 32'd6) begin
         n_bad++;
         $display("FAIL t0_claim rd=%0d exp 6", got_rd);
      end
      idle(3);
      rd(clm_a(1));
      n_cmp++;
      if (got_rd !== 32'd0 || irq !== 2'b00) begin
         n_bad++;
         $display("FAIL t1_claim rd=%0d irq=%b exp 0/00", got_rd, irq);
      end
      PRESETn = 1'b0;
      idle(2);
      PRESETn = 1'b1;
      rd(26'h1000);
      n_cmp++;
      if (got_rd !== 32'h0) begin
         n_bad++;
         $display("FAIL rst_discard pend=%h exp 0", got_rd);
      end
      idle(4);
      rd(26'h1000);
      n_cmp++;
      if (got_rd !== 32'h40 || irq !== 2'b00) begin
         n_bad++;
         $display("FAIL rst_repend pend=%h irq=%b exp 40/00", got_rd, irq);
      end
      src[5] = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arbitration();
      test_threshold();
      test_illegal();
      test_two_targets();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
